// File: rtl/stage_pkg.sv
// Shared constants, FSM state type and map address helper for the stage tile fetcher.
// STAGE_QUERY_EN adds the query state used by the random-access query port.
package stage_pkg;

    localparam int unsigned MAP_COLS   = 40;
    localparam int unsigned MAP_ROWS   = 32;
    localparam int unsigned VIS_ROWS   = 30;
    localparam int unsigned TILE_SHIFT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
`ifdef STAGE_QUERY_EN
        StDrain,
        StQuery
`else
        StDrain
`endif
    } fetch_state_e;

    // row*40 + col built from shifts; 31*40+39 = 1279 fits in 11 bits
    function automatic logic [10:0] map_addr(input logic [4:0] row, input logic [5:0] col);
        logic [10:0] r;
        r = {6'd0, row};
        return (r << 5) + (r << 3) + {5'd0, col};
    endfunction

endpackage

// File: rtl/stage_line_buf.sv
// Double-buffered tile-row buffer: the front bank feeds the pixel path, the back bank
// takes fetched tiles, and swap exchanges the two.
module stage_line_buf
    import stage_pkg::*;
#(
    parameter int unsigned COLS = stage_pkg::MAP_COLS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       swap,
    input  logic       wr_en,
    input  logic [5:0] wr_col,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_col,
    output logic [7:0] rd_data
);

    logic       front_sel;
    logic [7:0] mem [2][COLS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel <= 1'b0;
            mem       <= '{default: '0};
        end else begin
            if (swap) begin
                front_sel <= ~front_sel;
            end
            // Writes land in the bank that is back before any swap on this edge
            if (wr_en && (32'(wr_col) < COLS)) begin
                mem[~front_sel][wr_col] <= wr_data;
            end
        end
    end

    assign rd_data = (32'(rd_col) < COLS) ? mem[front_sel][rd_col] : 8'h00;

endmodule

// File: rtl/stage_tile_fetch.sv
// Stage tile fetcher: prefetches the next map row into a line buffer and serves tile codes
// to the pixel path. Define STAGE_QUERY_EN to build the random-access query port.
module stage_tile_fetch
    import stage_pkg::*;
#(
    parameter int unsigned MAP_COLS = stage_pkg::MAP_COLS,
    parameter int unsigned MAP_ROWS = stage_pkg::MAP_ROWS,
    parameter int unsigned VIS_ROWS = stage_pkg::VIS_ROWS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  pix_x,
    output logic [7:0]  tile_code,
    output logic [3:0]  tile_px,
    output logic [3:0]  tile_py,
    output logic [10:0] stage_address,
    output logic        stage_clken,
    input  logic [7:0]  stage_readdata,
    input  logic        query_valid,
    input  logic [5:0]  query_col,
    input  logic [4:0]  query_row,
    output logic        query_ready,
    output logic        result_valid,
    output logic [7:0]  result_tile,
    output logic        fetch_busy,
    output logic        fetch_overrun
);

    localparam int unsigned PIX_LIMIT = MAP_COLS << TILE_SHIFT;

    fetch_state_e state_q;
    logic [4:0]   fetch_row_q;
    logic [5:0]   fetch_col_q;
    logic         rd_valid_q;
    logic [5:0]   rd_col_q;
    logic         wr_en_q;
    logic [5:0]   wr_col_q;
    logic [7:0]   wr_data_q;
    logic [6:0]   next_row;
    logic         trig_line;
    logic         trigger;
    logic         swap;
    logic [4:0]   trig_row;
    logic [7:0]   buf_rd;

    always_comb begin
        next_row  = {1'b0, line_y[9:4]} + 7'd1;
        trig_line = line_start && (line_y[3:0] == 4'hF) && (32'(next_row) < VIS_ROWS)
                    && (32'(next_row) < MAP_ROWS);
        trigger   = frame_start || trig_line;
        trig_row  = frame_start ? 5'd0 : next_row[4:0];
        swap      = line_start && (line_y[3:0] == 4'h0);
    end

    assign stage_clken = reset_n;

`ifdef STAGE_QUERY_EN
    logic       q_oob;
    logic       q_accept;
    logic       q_pend1_q;
    logic       q_pend2_q;
    logic       q_oob1_q;
    logic [7:0] q_data_q;

    assign q_oob       = (32'(query_col) >= MAP_COLS) || (32'(query_row) >= MAP_ROWS);
    assign query_ready = reset_n && (state_q == StIdle) && !trigger;
    assign q_accept    = query_valid && query_ready;
`else
    logic unused_query;

    assign unused_query = ^{query_valid, query_col, query_row};
    assign query_ready  = 1'b0;
    assign result_valid = 1'b0;
    assign result_tile  = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            fetch_row_q   <= '0;
            fetch_col_q   <= '0;
            rd_valid_q    <= 1'b0;
            rd_col_q      <= '0;
            wr_en_q       <= 1'b0;
            wr_col_q      <= '0;
            wr_data_q     <= '0;
            stage_address <= '0;
            fetch_busy    <= 1'b0;
            fetch_overrun <= 1'b0;
`ifdef STAGE_QUERY_EN
            q_pend1_q     <= 1'b0;
            q_pend2_q     <= 1'b0;
            q_oob1_q      <= 1'b0;
            q_data_q      <= '0;
            result_valid  <= 1'b0;
            result_tile   <= '0;
`endif
        end else begin
            // Read data is registered once before the bank write
            rd_valid_q <= 1'b0;
            wr_en_q    <= rd_valid_q;
            wr_col_q   <= rd_col_q;
            wr_data_q  <= stage_readdata;

            if (frame_start) begin
                fetch_overrun <= 1'b0;
            end else if (swap && fetch_busy) begin
                fetch_overrun <= 1'b1;
            end

`ifdef STAGE_QUERY_EN
            // Query pipeline runs beside the FSM so a later trigger cannot lose it
            q_pend1_q    <= 1'b0;
            q_pend2_q    <= q_pend1_q;
            result_valid <= q_pend2_q;
            if (q_pend1_q) begin
                q_data_q <= q_oob1_q ? 8'h00 : stage_readdata;
            end
            if (q_pend2_q) begin
                result_tile <= q_data_q;
            end
`endif

            if (trigger) begin
                state_q     <= StFetch;
                fetch_row_q <= trig_row;
                fetch_col_q <= '0;
                fetch_busy  <= 1'b1;
                wr_en_q     <= 1'b0;
            end else if (swap && fetch_busy) begin
                state_q    <= StIdle;
                fetch_busy <= 1'b0;
                wr_en_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
`ifdef STAGE_QUERY_EN
                        if (q_accept) begin
                            state_q   <= StQuery;
                            q_pend1_q <= 1'b1;
                            q_oob1_q  <= q_oob;
                            if (!q_oob) begin
                                stage_address <= map_addr(query_row, query_col);
                            end
                        end
`endif
                    end
                    StFetch: begin
                        stage_address <= map_addr(fetch_row_q, fetch_col_q);
                        rd_valid_q    <= 1'b1;
                        rd_col_q      <= fetch_col_q;
                        fetch_col_q   <= fetch_col_q + 6'd1;
                        if (32'(fetch_col_q) == MAP_COLS - 1) begin
                            state_q <= StDrain;
                        end
                    end
                    StDrain: begin
                        if (wr_en_q && (32'(wr_col_q) == MAP_COLS - 1)) begin
                            state_q    <= StIdle;
                            fetch_busy <= 1'b0;
                        end
                    end
`ifdef STAGE_QUERY_EN
                    StQuery: begin
                        state_q <= StIdle;
                    end
`endif
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    stage_line_buf #(
        .COLS (MAP_COLS)
    ) u_line_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .swap    (swap),
        .wr_en   (wr_en_q),
        .wr_col  (wr_col_q),
        .wr_data (wr_data_q),
        .rd_col  (pix_x[9:4]),
        .rd_data (buf_rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tile_code <= '0;
            tile_px   <= '0;
            tile_py   <= '0;
        end else begin
            tile_code <= (32'(pix_x) < PIX_LIMIT) ? buf_rd : 8'h00;
            tile_px   <= pix_x[3:0];
            if (line_start) begin
                tile_py <= line_y[3:0];
            end
        end
    end

endmodule

// File: tb/tb_stage_tile_fetch.sv
// Self-checking bench for stage_tile_fetch: table-driven pixel vectors through a scoreboard
// queue plus hand-written fetch, overrun, restart, query and reset sequences.
module tb_stage_tile_fetch;

    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic        line_start;
    logic [9:0]  line_y;
    logic [9:0]  pix_x;
    logic [7:0]  tile_code;
    logic [3:0]  tile_px;
    logic [3:0]  tile_py;
    logic [10:0] stage_address;
    logic        stage_clken;
    logic [7:0]  stage_readdata;
    logic        query_valid;
    logic [5:0]  query_col;
    logic [4:0]  query_row;
    logic        query_ready;
    logic        result_valid;
    logic [7:0]  result_tile;
    logic        fetch_busy;
    logic        fetch_overrun;

    stage_tile_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .line_start     (line_start),
        .line_y         (line_y),
        .pix_x          (pix_x),
        .tile_code      (tile_code),
        .tile_px        (tile_px),
        .tile_py        (tile_py),
        .stage_address  (stage_address),
        .stage_clken    (stage_clken),
        .stage_readdata (stage_readdata),
        .query_valid    (query_valid),
        .query_col      (query_col),
        .query_row      (query_row),
        .query_ready    (query_ready),
        .result_valid   (result_valid),
        .result_tile    (result_tile),
        .fetch_busy     (fetch_busy),
        .fetch_overrun  (fetch_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage RAM model: map[r][c] = (r*40 + c) mod 256, data follows the registered address
    logic [7:0] ram [1280];
    initial begin
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 40; c++) begin
                ram[r * 40 + c] = 8'((r * 40 + c) % 256);
            end
        end
    end
    assign stage_readdata = (stage_address < 11'd1280) ? ram[stage_address] : 8'hEE;

    typedef struct {
        logic [9:0] pix;
        logic [7:0] code;
        logic [3:0] px;
    } pix_vec_t;

    typedef struct {
        logic [7:0] code;
        logic [3:0] px;
    } pix_exp_t;

    pix_exp_t   exp_q [$];
    logic [7:0] res_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic pulse_line(input logic [9:0] y);
        line_y     = y;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic run_pix(input string name, input pix_vec_t v);
        pix_exp_t e;
        pix_x = v.pix;
        exp_q.push_back('{v.code, v.px});
        step();
        e = exp_q.pop_front();
        check({name, "_code"}, tile_code, e.code);
        check({name, "_px"}, tile_px, e.px);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (fetch_busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (fetch_busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, fetch_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    pix_vec_t row0_tab [7];
    pix_vec_t row1_tab [4];
    pix_vec_t rst_tab  [2];

    initial begin
        int         n;
        int         seen;
        logic [10:0] addr_before;

        row0_tab = '{'{10'd0,   8'd0,  4'd0},  '{10'd15,  8'd0,  4'd15},
                     '{10'd16,  8'd1,  4'd0},  '{10'd100, 8'd6,  4'd4},
                     '{10'd639, 8'd39, 4'd15}, '{10'd640, 8'd0,  4'd0},
                     '{10'd1023, 8'd0, 4'd15}};
        row1_tab = '{'{10'd639, 8'd79, 4'd15}, '{10'd0,   8'd40, 4'd0},
                     '{10'd320, 8'd60, 4'd0},  '{10'd100, 8'd46, 4'd4}};
        rst_tab  = '{'{10'd160, 8'd50, 4'd0},  '{10'd0,   8'd40, 4'd0}};

        reset_n     = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        line_y      = '0;
        pix_x       = '0;
        query_valid = 1'b0;
        query_col   = '0;
        query_row   = '0;

        #12;
        check("rst_tile_code", tile_code, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_overrun", fetch_overrun, 0);
        check("rst_clken", stage_clken, 0);
        check("rst_query_ready", query_ready, 0);
        check("rst_address", stage_address, 0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("clken_run", stage_clken, 1);

        // Frame fetch of row 0
        pulse_frame();
        measure_busy(n);
        check("busy_len_frame", n, 42);
        run_pix("pre_swap", '{10'd100, 8'd0, 4'd4});

        pulse_line(10'd0);
        check("tile_py_0", tile_py, 0);
        for (int i = 0; i < 7; i++) begin
            run_pix("row0", row0_tab[i]);
        end

        // y=15 prefetches row 1 into the back bank while row 0 stays visible
        pulse_line(10'd15);
        check("busy_row1", fetch_busy, 1);
        check("tile_py_15", tile_py, 15);
        run_pix("row0_during_fetch", '{10'd100, 8'd6, 4'd4});
        wait_idle("row1_done");
        check("no_overrun", fetch_overrun, 0);

        pulse_line(10'd16);
        check("tile_py_16", tile_py, 0);
        for (int i = 0; i < 4; i++) begin
            run_pix("row1", row1_tab[i]);
        end

`ifdef STAGE_QUERY_EN
        check("q_ready_idle", query_ready, 1);
        query_col   = 6'd39;
        query_row   = 5'd31;
        query_valid = 1'b1;
        res_q.push_back(8'hFF);
        step();
        query_valid = 1'b0;
        check("q_addr", stage_address, 1279);
        check("q_rv_1", result_valid, 0);
        step();
        check("q_rv_2", result_valid, 0);
        step();
        check("q_rv_3", result_valid, 1);
        check("q_tile", result_tile, res_q.pop_front());
        step();
        check("q_rv_pulse", result_valid, 0);

        addr_before = stage_address;
        query_col   = 6'd45;
        query_row   = 5'd3;
        query_valid = 1'b1;
        res_q.push_back(8'h00);
        step();
        query_valid = 1'b0;
        check("q_oob_addr", stage_address, addr_before);
        step();
        step();
        check("q_oob_rv", result_valid, 1);
        check("q_oob_tile", result_tile, res_q.pop_front());

        // A fetch trigger in the same cycle blocks the query
        query_col   = 6'd5;
        query_row   = 5'd0;
        query_valid = 1'b1;
        frame_start = 1'b1;
        #1;
        check("q_ready_trig", query_ready, 0);
        step();
        frame_start = 1'b0;
        seen = 0;
        n    = 0;
        while (fetch_busy === 1'b1 && n < 100) begin
            if (query_ready !== 1'b0) seen++;
            step();
            n++;
        end
        check("q_ready_busy", seen, 0);
        check("q_ready_after", query_ready, 1);
        res_q.push_back(8'd5);
        step();
        query_valid = 1'b0;
        step();
        step();
        check("q_fetch_rv", result_valid, 1);
        check("q_fetch_tile", result_tile, res_q.pop_front());
`else
        query_col   = 6'd39;
        query_row   = 5'd31;
        query_valid = 1'b1;
        #1;
        check("q_ready_off", query_ready, 0);
        step();
        step();
        step();
        query_valid = 1'b0;
        check("q_rv_off", result_valid, 0);
        check("q_tile_off", result_tile, 0);
`endif

        // Swap 10 cycles into a fetch: abort and flag overrun
        pulse_line(10'd31);
        check("busy_row2", fetch_busy, 1);
        repeat (9) step();
        pulse_line(10'd32);
        check("overrun_set", fetch_overrun, 1);
        check("overrun_abort", fetch_busy, 0);
        step();
        check("overrun_sticky", fetch_overrun, 1);
        pulse_frame();
        check("overrun_clear", fetch_overrun, 0);
        check("frame_busy", fetch_busy, 1);

        // New trigger mid-fetch restarts at col 0 for the new row
        repeat (4) step();
        pulse_line(10'd15);
        measure_busy(n);
        check("busy_len_restart", n, 42);
        pulse_line(10'd16);
        for (int i = 0; i < 2; i++) begin
            run_pix("restart", rst_tab[i]);
        end

        // Last visible tile row has nothing to prefetch
        pulse_line(10'd479);
        check("no_fetch_last", fetch_busy, 0);

        // Asynchronous reset mid-fetch
        run_pix("pre_reset", '{10'd100, 8'd46, 4'd4});
        pulse_frame();
        repeat (5) step();
        check("mid_fetch_busy", fetch_busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_busy", fetch_busy, 0);
        check("async_tile_code", tile_code, 0);
        check("async_address", stage_address, 0);
        step();
        step();
        reset_n = 1'b1;
        run_pix("post_reset", '{10'd100, 8'd0, 4'd4});
        check("post_reset_busy", fetch_busy, 0);
        pulse_line(10'd0);
        run_pix("post_reset_swap", '{10'd100, 8'd0, 4'd4});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
